ram_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-port 8-bit-address/8-bit-data block RAM between NCORES processor cores.
- Each core presents a level request with its own address, write data and write enable, and receives a one-cycle ack.
- Read data is returned on the core's own byte lane of a packed bus.
- Sits between the core array and the shared data RAM; it replaces the fixed-priority access path with fair, fully sequenced single-beat transactions.

---
 rtl/ram_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_ram_rr_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port 8-bit RAM among NCORES cores.
// Define ARB_LOCK_EN to add the per-core lock input that holds a grant across transactions.
module ram_rr_arbiter #(
    parameter int NCORES = 4,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCORES-1:0]     req,
    input  logic [NCORES-1:0]     we,
    input  logic [NCORES*8-1:0]   addr,
    input  logic [NCORES*8-1:0]   wdata,
`ifdef ARB_LOCK_EN
    input  logic [NCORES-1:0]     lock,
`endif
    output logic [NCORES*8-1:0]   rdata,
    output logic [NCORES-1:0]     ack,
    output logic [7:0]            ram_addr,
    output logic [7:0]            ram_din,
    output logic                  ram_wren,
    input  logic [7:0]            ram_q,
    output logic                  busy,
    output logic [2:0]            grant_id
);

    generate
        if (NCORES < 2 || NCORES > 8 || RD_LAT < 1 || RD_LAT > 4) begin : g_bad_params
            $error("ram_rr_arbiter: NCORES must be 2..8 and RD_LAT 1..4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t              state;
    logic [2:0]          ptr;
    logic [2:0]          start;
    logic [2:0]          sel;
    logic                found;
    logic                sel_we;
    logic [1:0]          cnt;
    logic [NCORES-1:0]   req_rot;
    logic [NCORES-1:0]   ack_oh;
    logic [NCORES*8-1:0] lane_mask;
    logic [NCORES*8-1:0] lane_q;

    function automatic logic [2:0] next_idx(input logic [2:0] i);
        return (i == 3'(NCORES - 1)) ? 3'd0 : i + 3'd1;
    endfunction

`ifdef ARB_LOCK_EN
    logic       lock_valid;
    logic [2:0] lock_owner;
    logic       owner_req;
    logic       lock_g;

    assign owner_req = |(req & (NCORES'(1) << lock_owner));
    assign lock_g    = |(lock & (NCORES'(1) << grant_id));
    // Starting the scan at the owner grants it if still requesting, else falls through to owner+1.
    assign start     = lock_valid ? lock_owner : ptr;
`else
    assign start     = ptr;
`endif

    assign req_rot   = NCORES'({req, req} >> start);
    assign sel_we    = |(we & (NCORES'(1) << sel));
    assign ack_oh    = NCORES'(1) << grant_id;
    assign lane_mask = {{(NCORES*8-8){1'b0}}, 8'hFF} << {grant_id, 3'b000};
    assign lane_q    = {{(NCORES*8-8){1'b0}}, ram_q} << {grant_id, 3'b000};

    always_comb begin
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        sel   = start;
        for (int unsigned k = 0; k < NCORES; k++) begin
            if (!found && |(req_rot & (NCORES'(1) << k))) begin
                found = 1'b1;
                idx   = 32'(start) + k;
                if (idx >= NCORES) idx = idx - NCORES;
                sel   = 3'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            ack      <= '0;
            rdata    <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_wren <= 1'b0;
            busy     <= 1'b0;
            grant_id <= '0;
            cnt      <= '0;
`ifdef ARB_LOCK_EN
            lock_valid <= 1'b0;
            lock_owner <= '0;
`endif
        end else begin
            ack <= '0;
            unique case (state)
                IDLE: begin
`ifdef ARB_LOCK_EN
                    if (lock_valid && !owner_req) begin
                        lock_valid <= 1'b0;
                        ptr        <= next_idx(lock_owner);
                    end
`endif
                    if (found) begin
                        grant_id <= sel;
                        ram_addr <= 8'(addr >> {sel, 3'b000});
                        ram_din  <= 8'(wdata >> {sel, 3'b000});
                        ram_wren <= sel_we;
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    ram_wren <= 1'b0;
                    if (ram_wren) begin
                        ack   <= ack_oh;
                        state <= ACK;
                    end else begin
                        cnt   <= 2'(RD_LAT - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        rdata <= (rdata & ~lane_mask) | lane_q;
                        ack   <= ack_oh;
                        state <= ACK;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
`ifdef ARB_LOCK_EN
                    if (lock_g) begin
                        lock_valid <= 1'b1;
                        lock_owner <= grant_id;
                    end else begin
                        lock_valid <= 1'b0;
                        ptr        <= next_idx(grant_id);
                    end
`else
                    ptr <= next_idx(grant_id);
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Self-checking bench for ram_rr_arbiter: directed scenarios plus random traffic
// checked against a transaction-level round-robin/memory model.
module tb_ram_rr_arbiter;
    localparam int N  = 4;
    localparam int RL = 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req, we, ack;
    logic [N*8-1:0] addr, wdata, rdata;
    logic [7:0]     ram_addr, ram_din, ram_q;
    logic           ram_wren, busy;
    logic [2:0]     grant_id;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_rr_arbiter #(.NCORES(N), .RD_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_wren(ram_wren), .ram_q(ram_q), .busy(busy), .grant_id(grant_id)
    );

    // Environment RAM: contents preset to addr^0x29 while in reset, RL-cycle read pipeline.
    logic [7:0] mem [256];
    logic [7:0] qpipe [RL];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int a = 0; a < 256; a++) mem[a] <= 8'(a) ^ 8'h29;
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_din;
        end
        qpipe[0] <= mem[ram_addr];
        for (int k = 1; k < RL; k++) qpipe[k] <= qpipe[k-1];
    end
    assign ram_q = qpipe[RL-1];

    // Reference model state
    int         ptr_m;
    logic [7:0] mem_m [256];
    logic [7:0] rd_m  [N];
    bit         pend  [N];
    bit         pwe   [N];
    logic [7:0] pad   [N];
    logic [7:0] pwd   [N];
    int         waited[N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        ptr_m = 0;
        for (int a = 0; a < 256; a++) mem_m[a] = 8'(a) ^ 8'h29;
        for (int i = 0; i < N; i++) begin rd_m[i] = 8'h00; waited[i] = 0; end
    endtask

    function automatic logic [N*8-1:0] pack_rd();
        logic [N*8-1:0] r;
        for (int i = 0; i < N; i++) r[i*8 +: 8] = rd_m[i];
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req[i]           = pend[i];
            we[i]            = pwe[i];
            addr[i*8 +: 8]   = pad[i];
            wdata[i*8 +: 8]  = pwd[i];
        end
    endtask

    task automatic new_op(input int i);
        pend[i] = 1'b1;
        pwe[i]  = 1'($urandom_range(1, 0));
        pad[i]  = 8'($urandom_range(15, 0));
        pwd[i]  = 8'($urandom);
    endtask

    task automatic clear_pend();
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
    endtask

    // One transaction from the IDLE sampling edge through the return to IDLE.
    task automatic do_txn(input bit keep, output int g);
        int         lat;
        bit         w;
        logic [7:0] a, d;
        logic [N-1:0] oh;
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && pend[(ptr_m + k) % N]) g = (ptr_m + k) % N;
        if (g < 0) begin
            chk("no_request_pending", 64'(0), 64'(1));
            g = 0;
            return;
        end
        w = pwe[g]; a = pad[g]; d = pwd[g];
        lat = w ? 2 : RL + 2;
        tick();
        chk("grant_busy", 64'(busy), 64'(1));
        chk("grant_id", 64'(grant_id), 64'(g));
        chk("ram_addr", 64'(ram_addr), 64'(a));
        chk("ram_din", 64'(ram_din), 64'(d));
        chk("ram_wren_issue", 64'(ram_wren), 64'(w));
        // Change the granted core's lane mid-flight; the latched transaction must not see it.
        pwe[g] = 1'($urandom_range(1, 0));
        pad[g] = 8'($urandom);
        pwd[g] = 8'($urandom);
        drive();
        for (int c = 1; c < lat - 1; c++) begin
            tick();
            chk("ack_early", 64'(ack), 64'(0));
            chk("ram_wren_once", 64'(ram_wren), 64'(0));
        end
        tick();
        oh = '0;
        oh[g] = 1'b1;
        chk("ack", 64'(ack), 64'(oh));
        chk("ram_wren_ack", 64'(ram_wren), 64'(0));
        if (w) mem_m[a] = d;
        else   rd_m[g] = mem_m[a];
        ptr_m = (g + 1) % N;
        chk("rdata", 64'(rdata), 64'(pack_rd()));
        if (!keep) pend[g] = 1'b0;
        drive();
        tick();
        chk("busy_idle", 64'(busy), 64'(0));
        chk("ack_cleared", 64'(ack), 64'(0));
    endtask

    initial begin
        int g, g1;
        bit ok;

        // Reset with every core requesting
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1; pwe[i] = 1'b1; pad[i] = 8'h40 + 8'(i); pwd[i] = 8'h10 + 8'(i);
        end
        drive();
        model_reset();
        repeat (3) tick();
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_wren", 64'(ram_wren), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(0));
        chk("rst_rdata", 64'(rdata), 64'(0));
        rst_n = 1'b1;

        // Contention: all four held until acked
        for (int k = 0; k < N; k++) begin
            do_txn(1'b0, g);
            chk("contention_order", 64'(g), 64'(k));
        end

        // Fairness: cores 1 and 3 re-request right after each ack
        clear_pend();
        new_op(1);
        new_op(3);
        for (int t = 0; t < 8; t++) begin
            drive();
            do_txn(1'b0, g);
            chk("fair_order", 64'(g), 64'((t % 2) ? 3 : 1));
            new_op(g);
        end
        clear_pend();

        // Read, core 1, addr 0x15 (RAM holds 0x3C)
        pend[1] = 1'b1; pwe[1] = 1'b0; pad[1] = 8'h15; pwd[1] = 8'h00;
        drive();
        do_txn(1'b0, g);
        chk("read_lane1", 64'(rdata[15:8]), 64'(8'h3C));

        // Single write, core 2
        pend[2] = 1'b1; pwe[2] = 1'b1; pad[2] = 8'h15; pwd[2] = 8'hA5;
        drive();
        do_txn(1'b0, g);
        chk("write_grant", 64'(g), 64'(2));

        // Read back through core 0
        pend[0] = 1'b1; pwe[0] = 1'b0; pad[0] = 8'h15;
        drive();
        do_txn(1'b0, g);
        chk("readback_lane0", 64'(rdata[7:0]), 64'(8'hA5));

        // Req held through the ack cycle produces a second access
        pend[0] = 1'b1; pwe[0] = 1'b1; pad[0] = 8'h07; pwd[0] = 8'h5E;
        drive();
        do_txn(1'b1, g);
        do_txn(1'b0, g1);
        chk("double_access", 64'(g1), 64'(0));

        // Random traffic with starvation bound
        for (int i = 0; i < N; i++) waited[i] = 0;
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++)
                if (!pend[i] && $urandom_range(1, 0) == 1) new_op(i);
            ok = 1'b0;
            for (int i = 0; i < N; i++) ok |= pend[i];
            if (!ok) new_op($urandom_range(N - 1, 0));
            drive();
            do_txn(1'b0, g);
            ok = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (i == g) waited[i] = 0;
                else if (pend[i]) waited[i]++;
                if (waited[i] >= N) ok = 1'b0;
            end
            chk("no_starvation", 64'(ok), 64'(1));
        end

        // Reset during WAIT aborts the read
        clear_pend();
        pend[2] = 1'b1; pwe[2] = 1'b0; pad[2] = 8'h03;
        drive();
        tick();
        chk("abort_grant", 64'(grant_id), 64'(2));
        tick();
        rst_n = 1'b0;
        tick();
        chk("abort_ack", 64'(ack), 64'(0));
        chk("abort_wren", 64'(ram_wren), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_rdata", 64'(rdata), 64'(0));
        model_reset();
        clear_pend();
        drive();
        tick();
        chk("abort_ack_late", 64'(ack), 64'(0));
        rst_n = 1'b1;

        // Traffic resumes after reset
        pend[3] = 1'b1; pwe[3] = 1'b0; pad[3] = 8'h15;
        drive();
        do_txn(1'b0, g);
        chk("post_reset_read", 64'(rdata[31:24]), 64'(8'h3C));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
